// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory target: decodes READ (0x03) / WRITE (0x02) with a 24-bit
// big-endian address and serves a small byte array with auto-increment.
// All SPI pins are sampled into the clk domain; the SPI clock is treated as
// a slow data signal whose edges are found from synchronised history.
module spi_mem_responder #(
    parameter int DEPTH = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic busy
);

    localparam int AW = $clog2(DEPTH);
    // Shift register only needs the low address bits or a full command byte.
    localparam int SW = (AW > 8) ? AW : 8;
    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_RD     = 3'd3;
    localparam logic [2:0] ST_WR     = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    logic          sclk_q1_r, sclk_q2_r, sclk_q3_r;
    logic          cs_n_q1_r, cs_n_q2_r;
    logic          mosi_q1_r, mosi_q2_r;
    logic [2:0]    state_r;
    logic [4:0]    bit_cnt_r;
    logic [SW-2:0] shift_r;
    logic          is_read_r;
    logic [AW-1:0] index_r;
    logic [7:0]    tx_r;
    logic          miso_r;
    logic          busy_r;
    logic          wr_en_r;
    logic [AW-1:0] wr_addr_r;
    logic [7:0]    wr_data_r;
    logic [7:0]    mem_r [DEPTH];

    logic          rise_s;
    logic          fall_s;
    logic [SW-1:0] next_shift_s;
    logic [AW-1:0] new_index_s;
    logic [7:0]    cmd_s;
    logic [7:0]    first_rd_s;
    logic [7:0]    next_rd_s;

    assign rise_s       = sclk_q2_r & ~sclk_q3_r;
    assign fall_s       = ~sclk_q2_r & sclk_q3_r;
    assign next_shift_s = {shift_r, mosi_q2_r};
    assign new_index_s  = next_shift_s[AW-1:0];
    assign cmd_s        = next_shift_s[7:0];
    assign first_rd_s   = mem_r[new_index_s];
    assign next_rd_s    = mem_r[index_r + IDX_ONE];

    assign miso = miso_r;
    assign busy = busy_r;

    // Two-flop synchronisers plus one extra sclk stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q1_r <= 1'b0;
            sclk_q2_r <= 1'b0;
            sclk_q3_r <= 1'b0;
            cs_n_q1_r <= 1'b1;
            cs_n_q2_r <= 1'b1;
            mosi_q1_r <= 1'b0;
            mosi_q2_r <= 1'b0;
        end else begin
            sclk_q1_r <= sclk;
            sclk_q2_r <= sclk_q1_r;
            sclk_q3_r <= sclk_q2_r;
            cs_n_q1_r <= cs_n;
            cs_n_q2_r <= cs_n_q1_r;
            mosi_q1_r <= mosi;
            mosi_q2_r <= mosi_q1_r;
        end
    end

    // Protocol FSM: command/address decode, read shifting and write assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 5'd0;
            shift_r   <= '0;
            is_read_r <= 1'b0;
            index_r   <= '0;
            tx_r      <= 8'h00;
            miso_r    <= 1'b0;
            busy_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 8'h00;
        end else begin
            wr_en_r <= 1'b0;
            if (cs_n_q2_r) begin
                // Deselect abandons any partial byte in every state.
                state_r   <= ST_IDLE;
                bit_cnt_r <= 5'd0;
                shift_r   <= '0;
                is_read_r <= 1'b0;
                index_r   <= '0;
                tx_r      <= 8'h00;
                miso_r    <= 1'b0;
                busy_r    <= 1'b0;
            end else begin
                busy_r <= 1'b1;
                case (state_r)
                    ST_IDLE: begin
                        state_r   <= ST_CMD;
                        bit_cnt_r <= 5'd0;
                    end
                    ST_CMD: begin
                        if (rise_s) begin
                            shift_r <= next_shift_s[SW-2:0];
                            if (bit_cnt_r == 5'd7) begin
                                bit_cnt_r <= 5'd0;
                                if (cmd_s == CMD_READ) begin
                                    state_r   <= ST_ADDR;
                                    is_read_r <= 1'b1;
                                end else if (cmd_s == CMD_WRITE) begin
                                    state_r   <= ST_ADDR;
                                    is_read_r <= 1'b0;
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (rise_s) begin
                            shift_r <= next_shift_s[SW-2:0];
                            if (bit_cnt_r == 5'd23) begin
                                bit_cnt_r <= 5'd0;
                                index_r   <= new_index_s;
                                if (is_read_r) begin
                                    tx_r    <= first_rd_s;
                                    state_r <= ST_RD;
                                end else begin
                                    state_r <= ST_WR;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_RD: begin
                        if (fall_s) begin
                            miso_r <= tx_r[7];
                            tx_r   <= {tx_r[6:0], 1'b0};
                        end
                        if (rise_s) begin
                            if (bit_cnt_r == 5'd7) begin
                                // Reload well before the next fall edge.
                                bit_cnt_r <= 5'd0;
                                index_r   <= index_r + IDX_ONE;
                                tx_r      <= next_rd_s;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_WR: begin
                        if (rise_s) begin
                            shift_r <= next_shift_s[SW-2:0];
                            if (bit_cnt_r == 5'd7) begin
                                bit_cnt_r <= 5'd0;
                                wr_en_r   <= 1'b1;
                                wr_addr_r <= index_r;
                                wr_data_r <= next_shift_s[7:0];
                                index_r   <= index_r + IDX_ONE;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        miso_r <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        miso_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Storage commit one clock after the completing bit; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_r) begin
            mem_r[wr_addr_r] <= wr_data_r;
        end
    end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: bit-bangs SPI mode 0 from the clk
// domain and compares returned bytes against hand-computed values.
module tb_spi_mem_responder;

    logic clk = 1'b0;
    logic rst_n;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic busy;

    int checks = 0;
    int failures = 0;
    int half = 6;

    spi_mem_responder #(.DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .cs_n  (cs_n),
        .mosi  (mosi),
        .miso  (miso),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of tx (MSB first); miso is sampled just before each rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit stab,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            ticks(half);
            rx[i] = miso;
            sclk = 1'b1;
            ticks(half);
            if (stab) chk("miso_stable", 32'(miso), 32'(rx[i]));
            sclk = 1'b0;
        end
    endtask

    task automatic begin_tx();
        cs_n = 1'b0;
        ticks(6);
    endtask

    task automatic end_tx();
        ticks(6);
        cs_n = 1'b1;
        mosi = 1'b0;
        ticks(8);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        logic [7:0] rx;
        xfer(cmd, 8, 1'b0, rx);
        xfer(addr[23:16], 8, 1'b0, rx);
        xfer(addr[15:8], 8, 1'b0, rx);
        xfer(addr[7:0], 8, 1'b0, rx);
    endtask

    task automatic wr(input logic [23:0] addr, input int n, input logic [31:0] data);
        logic [7:0] rx;
        begin_tx();
        send_hdr(8'h02, addr);
        for (int b = n - 1; b >= 0; b--) xfer(data[8*b +: 8], 8, 1'b0, rx);
        end_tx();
    endtask

    task automatic rd(input logic [23:0] addr, input int n, input bit stab,
                      output logic [31:0] got);
        logic [7:0] rx;
        got = 32'h0;
        begin_tx();
        send_hdr(8'h03, addr);
        for (int b = 0; b < n; b++) begin
            xfer(8'h00, 8, stab, rx);
            got = {got[23:0], rx};
        end
        end_tx();
    endtask

    initial begin
        logic [31:0] got;
        logic [7:0]  rx;
        logic [7:0]  acc;

        rst_n = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        ticks(3);
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        ticks(4);

        // Two-byte write then read back, busy tracking cs_n.
        begin_tx();
        xfer(8'h02, 8, 1'b0, rx);
        chk("busy_active", 32'(busy), 32'd1);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h10, 8, 1'b0, rx);
        xfer(8'hA5, 8, 1'b0, rx);
        xfer(8'h5A, 8, 1'b0, rx);
        end_tx();
        chk("busy_idle", 32'(busy), 32'd0);
        rd(24'h000010, 2, 1'b0, got);
        chk("rd_a5_5a", got, 32'h0000A55A);

        // Index wrap and ignored upper address bits.
        wr(24'h0000FF, 1, 32'h000000FF);
        wr(24'h000000, 1, 32'h00000011);
        rd(24'h0000FF, 2, 1'b0, got);
        chk("rd_wrap", got, 32'h0000FF11);
        rd(24'h1234FF, 1, 1'b0, got);
        chk("rd_upper_ignored", got, 32'h000000FF);

        // Unknown command: miso held low, memory untouched.
        begin_tx();
        xfer(8'h9F, 8, 1'b0, rx);
        acc = 8'h00;
        for (int b = 0; b < 5; b++) begin
            xfer(8'hFF, 8, 1'b0, rx);
            acc = acc | rx;
        end
        end_tx();
        chk("ignore_miso", 32'(acc), 32'd0);
        rd(24'h000010, 2, 1'b0, got);
        chk("ignore_no_write", got, 32'h0000A55A);

        // Partial trailing byte is discarded.
        wr(24'h000021, 1, 32'h00000077);
        begin_tx();
        send_hdr(8'h02, 24'h000020);
        xfer(8'h3C, 8, 1'b0, rx);
        xfer(8'hE8, 5, 1'b0, rx);
        end_tx();
        rd(24'h000020, 2, 1'b0, got);
        chk("partial_discard", got, 32'h00003C77);

        // Reset during a read data byte forces miso low.
        begin_tx();
        send_hdr(8'h03, 24'h0000FF);
        xfer(8'h00, 3, 1'b0, rx);
        chk("rd_before_reset", 32'(rx), 32'h000000E0);
        rst_n = 1'b0;
        ticks(1);
        chk("rst_rd_miso", 32'(miso), 32'd0);
        cs_n = 1'b1;
        ticks(3);
        rst_n = 1'b1;
        ticks(6);

        // Reset during the address phase of a write.
        begin_tx();
        xfer(8'h02, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        xfer(8'h10, 4, 1'b0, rx);
        rst_n = 1'b0;
        ticks(2);
        chk("rst_wr_miso", 32'(miso), 32'd0);
        chk("rst_wr_busy", 32'(busy), 32'd0);
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        ticks(4);
        rst_n = 1'b1;
        ticks(6);
        rd(24'h000010, 2, 1'b0, got);
        chk("after_rst_rd", got, 32'h0000A55A);
        rd(24'h000020, 1, 1'b0, got);
        chk("after_rst_keep", got, 32'h0000003C);

        // Minimum half period, 4-byte sequential read with stability checks.
        wr(24'h000040, 4, 32'hDEADBEEF);
        half = 4;
        rd(24'h000040, 4, 1'b1, got);
        chk("fast_rd4", got, 32'hDEADBEEF);
        half = 6;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
